fmap_weight_loader: RTL

Write-side controller for the NPU's on-chip fmap/weight/bias memory. Accepts a byte stream over a valid/ready handshake and drives the memory's 9-lane write port (`write_w`, `write_h`, `write`, `en`). It fills a configured rectangular region (fmap tile, weight sets, or the two bias columns) row by row, packing up to 9 consecutive columns per write cycle. It sits between the host/DMA byte stream and the memory, and signals completion to the layer sequencer.

---
 rtl/fmap_weight_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fmap_weight_loader.sv
// fmap_weight_loader: byte stream to 9-lane fmap/weight/bias memory writes.
// Ports: start/cfg_* request, in_* byte handshake, write_*/en memory port, busy/done/err status.
module fmap_weight_loader #(
  parameter int WIDTH    = 80,
  parameter int HEIGHT   = 8,
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3,
  parameter int BIAS     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH_B-1:0]  cfg_w0,
  input  logic [WIDTH_B-1:0]  cfg_cols,
  input  logic [HEIGHT_B:0]   cfg_rows,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH_B-1:0]  write_w,
  output logic [HEIGHT_B-1:0] write_h,
  output logic [71:0]         write,
  output logic [8:0]          en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [HEIGHT_B:0] HMAX = (HEIGHT_B+1)'(HEIGHT);
  localparam logic [WIDTH_B:0]  WMAX = (WIDTH_B+1)'(WIDTH + BIAS);
  localparam logic [WIDTH_B:0]  NINE = (WIDTH_B+1)'(9);
  localparam logic [WIDTH_B:0]  ONE  = (WIDTH_B+1)'(1);

  state_t              state_q;
  logic [WIDTH_B-1:0]  w0_q;
  logic [WIDTH_B:0]    end_q;
  logic [HEIGHT_B:0]   rows_q;
  logic [HEIGHT_B-1:0] row_q;
  logic [WIDTH_B-1:0]  col_q;
  logic [3:0]          k_q;
  logic [71:0]         write_q;
  logic [8:0]          en_q;
  logic [WIDTH_B-1:0]  write_w_q;
  logic [HEIGHT_B-1:0] write_h_q;
  logic                err_q;

  logic [WIDTH_B:0] sum_w;
  logic             cfg_bad;
  logic [WIDTH_B:0] rem;
  logic [WIDTH_B:0] clen;
  logic             last_byte;
  logic             more_cols;
  logic             more_rows;
  logic             accept;

  // Region end is kept one bit wider so w0+cols cannot wrap.
  assign sum_w   = {1'b0, cfg_w0} + {1'b0, cfg_cols};
  assign cfg_bad = (cfg_cols == '0) || (cfg_rows == '0) ||
                   (cfg_rows > HMAX) || (sum_w > WMAX);

  assign rem       = end_q - {1'b0, col_q};
  assign clen      = (rem > NINE) ? NINE : rem;
  assign last_byte = ((WIDTH_B+1)'(k_q) + ONE) == clen;
  assign more_cols = ({1'b0, col_q} + NINE) < end_q;
  assign more_rows = ({1'b0, row_q} + 1'b1) < rows_q;
  assign accept    = (state_q == FILL) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      w0_q      <= '0;
      end_q     <= '0;
      rows_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      write_q   <= '0;
      en_q      <= '0;
      write_w_q <= '0;
      write_h_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              w0_q    <= cfg_w0;
              end_q   <= sum_w;
              rows_q  <= cfg_rows;
              row_q   <= '0;
              col_q   <= cfg_w0;
              k_q     <= '0;
              write_q <= '0;
              state_q <= FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            for (int i = 0; i < 9; i++) begin
              if (k_q == 4'(i)) write_q[71-8*i -: 8] <= in_data;
            end
            k_q <= k_q + 4'd1;
            if (last_byte) begin
              // Lane k maps to en[8-k], so a chunk of n lanes sets the top n bits.
              en_q      <= ~(9'h1FF >> clen);
              write_w_q <= col_q;
              write_h_q <= row_q;
              state_q   <= WRITE;
            end
          end
        end
        WRITE: begin
          en_q    <= '0;
          write_q <= '0;
          k_q     <= '0;
          if (more_cols) begin
            col_q   <= col_q + WIDTH_B'(9);
            state_q <= FILL;
          end else if (more_rows) begin
            row_q   <= row_q + 1'b1;
            col_q   <= w0_q;
            state_q <= FILL;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == FILL);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign en       = en_q;
  assign write    = write_q;
  assign write_w  = write_w_q;
  assign write_h  = write_h_q;

endmodule
